// File: rtl/rx_regfile_dump.sv
// rx_regfile_dump
//   Receives the 128-byte register-file dump sent after each executed
//   instruction over an 8N1 UART. Rebuilds it as 32 little-endian words,
//   register 0 first, and strobes each word out as soon as it is complete.
//
// Ports
//   clk12       in   system clock; all logic on posedge
//   rstn        in   synchronous active-low reset
//   rx          in   UART serial input, idle high, asynchronous to clk12
//   word_valid  out  one-cycle strobe: word_addr/word_data hold a new word
//   word_addr   out  [4:0]  register index of the completed word
//   word_data   out  [31:0] completed word, lane 0 = first byte received
//   dump_done   out  one-cycle strobe together with word_valid for word 31
//   frame_err   out  one-cycle strobe when a stop bit is sampled low
//   timeout     out  one-cycle strobe when a partial dump is abandoned
//   busy        out  dump in progress or a confirmed byte being received
module rx_regfile_dump #(
  parameter int CLKS_PER_BIT = 104,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk12,
  input  logic        rstn,
  input  logic        rx,
  output logic        word_valid,
  output logic [4:0]  word_addr,
  output logic [31:0] word_data,
  output logic        dump_done,
  output logic        frame_err,
  output logic        timeout,
  output logic        busy
);

  localparam int DIV_W    = $clog2(CLKS_PER_BIT);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT);

  // The divider counts down to zero, so loads are one less than the span.
  localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DIV_W-1:0] FULL_LOAD = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               rx_meta_q, srx_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [6:0]         byte_count_q, byte_count_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  // Only lanes 0..2 are buffered; lane 3 goes straight from the shifter.
  logic [23:0]        word_buf_q, word_buf_d;
  logic               word_valid_q, word_valid_d;
  logic [4:0]         word_addr_q, word_addr_d;
  logic [31:0]        word_data_q, word_data_d;
  logic               dump_done_q, dump_done_d;
  logic               frame_err_q, frame_err_d;
  logic               timeout_q, timeout_d;

  logic sample_tick;
  logic byte_accept;

  assign sample_tick = (div_q == '0);
  assign byte_accept = (state_q == S_STOP) && sample_tick && srx_q;

  // Lane write-enable per buffered byte position.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign word_buf_d[8*gi +: 8] =
        (byte_accept && (byte_count_q[1:0] == 2'(gi))) ? shift_q
                                                       : word_buf_q[8*gi +: 8];
    end
  endgenerate

  // State register (includes the rx synchroniser).
  always_ff @(posedge clk12) begin
    if (!rstn) begin
      rx_meta_q    <= 1'b1;
      srx_q        <= 1'b1;
      state_q      <= S_IDLE;
      div_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_count_q <= '0;
      to_cnt_q     <= '0;
      word_buf_q   <= '0;
      word_valid_q <= 1'b0;
      word_addr_q  <= '0;
      word_data_q  <= '0;
      dump_done_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      srx_q        <= rx_meta_q;
      state_q      <= state_d;
      div_q        <= div_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_count_q <= byte_count_d;
      to_cnt_q     <= to_cnt_d;
      word_buf_q   <= word_buf_d;
      word_valid_q <= word_valid_d;
      word_addr_q  <= word_addr_d;
      word_data_q  <= word_data_d;
      dump_done_q  <= dump_done_d;
      frame_err_q  <= frame_err_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state logic: bit FSM, byte assembly and idle timeout.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_count_d = byte_count_q;
    to_cnt_d     = to_cnt_q;
    word_valid_d = 1'b0;
    word_addr_d  = word_addr_q;
    word_data_d  = word_data_q;
    dump_done_d  = 1'b0;
    frame_err_d  = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!srx_q) begin
          state_d = S_START;
          div_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (sample_tick) begin
          if (!srx_q) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
            div_d     = FULL_LOAD;
          end else begin
            // Start bit gone by mid-bit: treat as a glitch, silently.
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (sample_tick) begin
          shift_d = {srx_q, shift_q[7:1]};
          div_d   = FULL_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_STOP: begin
        if (sample_tick) begin
          state_d = S_IDLE;
          if (srx_q) begin
            byte_count_d = byte_count_q + 7'd1;
            if (byte_count_q[1:0] == 2'd3) begin
              word_valid_d = 1'b1;
              word_addr_d  = byte_count_q[6:2];
              word_data_d  = {shift_q, word_buf_q};
              dump_done_d  = &byte_count_q;
            end
          end else begin
            frame_err_d  = 1'b1;
            byte_count_d = '0;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Idle timer only runs between bytes of a partial dump. Its expiry
    // overrides the byte_count update; a start bit seen in the same cycle
    // still moves the FSM on, so that byte becomes byte 0 of a new dump.
    if ((state_q == S_IDLE) && (byte_count_q != '0)) begin
      if (to_cnt_q == TO_LAST) begin
        timeout_d    = 1'b1;
        byte_count_d = '0;
        to_cnt_d     = '0;
      end else if (!srx_q) begin
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Outputs. busy ignores the unconfirmed START phase so a rejected
  // glitch never shows up as activity.
  always_comb begin
    word_valid = word_valid_q;
    word_addr  = word_addr_q;
    word_data  = word_data_q;
    dump_done  = dump_done_q;
    frame_err  = frame_err_q;
    timeout    = timeout_q;
    busy       = (byte_count_q != '0) || (state_q == S_DATA) ||
                 (state_q == S_STOP);
  end

endmodule

// File: tb/tb_rx_regfile_dump.sv
// tb_rx_regfile_dump
//   Randomised UART byte streams against a byte-image reference model of the
//   dump receiver. The divider is shortened so full dumps stay short; the
//   glitch pulse is scaled to stay well under half a bit period.
`timescale 1ns/1ps
module tb_rx_regfile_dump;

  localparam int  CPB    = 12;
  localparam int  TOB    = 20;
  localparam real BIT_NS = CPB * 10.0;

  logic        clk12 = 1'b0;
  logic        rstn  = 1'b0;
  logic        rx    = 1'b1;
  logic        word_valid;
  logic [4:0]  word_addr;
  logic [31:0] word_data;
  logic        dump_done;
  logic        frame_err;
  logic        timeout;
  logic        busy;

  always #5 clk12 = ~clk12;

  rx_regfile_dump #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk12      (clk12),
    .rstn       (rstn),
    .rx         (rx),
    .word_valid (word_valid),
    .word_addr  (word_addr),
    .word_data  (word_data),
    .dump_done  (dump_done),
    .frame_err  (frame_err),
    .timeout    (timeout),
    .busy       (busy)
  );

  typedef struct packed {
    logic        done;
    logic [4:0]  addr;
    logic [31:0] data;
  } word_t;

  int    n_compared   = 0;
  int    n_mismatched = 0;
  word_t exp_q[$];
  word_t obs_log[$];
  word_t mon_exp;
  logic [7:0] m_img [128];
  int    m_cnt       = 0;
  int    exp_frame   = 0;
  int    exp_timeout = 0;
  int    obs_frame   = 0;
  int    obs_timeout = 0;
  int    obs_done    = 0;

  task automatic check_value(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: byte image, completed words come out in lane order.
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    word_t w;
    if (stop_ok) begin
      m_img[m_cnt] = b;
      if (m_cnt % 4 == 3) begin
        w.done = (m_cnt == 127);
        w.addr = 5'(m_cnt / 4);
        w.data = {m_img[m_cnt], m_img[m_cnt-1], m_img[m_cnt-2], m_img[m_cnt-3]};
        exp_q.push_back(w);
      end
      m_cnt = (m_cnt + 1) % 128;
    end else begin
      exp_frame++;
      m_cnt = 0;
    end
  endtask

  task automatic model_timeout();
    if (m_cnt != 0) begin
      exp_timeout++;
      m_cnt = 0;
    end
  endtask

  // Monitor: scoreboard every completed word, count the error strobes.
  always @(negedge clk12) begin
    if (rstn) begin
      if (word_valid) begin
        check_value("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check_value("word", 64'({dump_done, word_addr, word_data}), 64'(mon_exp));
        end
        obs_log.push_back({dump_done, word_addr, word_data});
        if (dump_done) obs_done++;
      end
      if (dump_done) check_value("done_with_valid", 64'(word_valid), 64'd1);
      if (frame_err) obs_frame++;
      if (timeout)   obs_timeout++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input real bit_ns);
    model_byte(b, stop_ok);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    if (stop_ok) begin
      rx = 1'b1;
      #(bit_ns);
    end else begin
      rx = 1'b0;
      #(bit_ns * 0.75);
      rx = 1'b1;
      #(bit_ns * 0.25);
    end
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk12);
  endtask

  // Quiet period longer than the timeout; any partial dump is abandoned.
  task automatic settle();
    idle_cycles((TOB + 2) * CPB);
    model_timeout();
    check_value("words_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(8'($urandom), 1'b1, BIT_NS);
      idle_cycles($urandom_range(0, 3 * CPB));
    end
  endtask

  task automatic send_dump_counting(input real bit_ns);
    for (int k = 0; k < 128; k++) send_byte(8'(k), 1'b1, bit_ns);
  endtask

  task automatic send_dump_random(input real bit_ns);
    for (int k = 0; k < 128; k++) send_byte(8'($urandom), 1'b1, bit_ns);
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int frames0;
    int timeouts0;
    int done0;
    bit busy_seen;

    // Reset held with rx toggling.
    rstn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rx = 1'($urandom);
      @(negedge clk12);
    end
    check_value("rst_word_valid", 64'(word_valid), 64'd0);
    check_value("rst_dump_done",  64'(dump_done),  64'd0);
    check_value("rst_frame_err",  64'(frame_err),  64'd0);
    check_value("rst_timeout",    64'(timeout),    64'd0);
    check_value("rst_busy",       64'(busy),       64'd0);
    check_value("rst_word_addr",  64'(word_addr),  64'd0);
    check_value("rst_word_data",  64'(word_data),  64'd0);
    rx = 1'b1;
    @(negedge clk12);
    rstn = 1'b1;
    idle_cycles(2 * CPB);

    // First byte after reset lands in lane 0 of reg 0.
    obs_log.delete();
    send_random(4);
    settle();
    check_value("post_rst_addr", 64'(obs_log[0].addr), 64'd0);

    // Reset mid-dump discards progress.
    send_random(3);
    @(negedge clk12);
    rstn = 1'b0;
    @(negedge clk12);
    rstn = 1'b1;
    m_cnt = 0;
    idle_cycles(2 * CPB);
    obs_log.delete();
    send_random(4);
    settle();
    check_value("mid_rst_addr", 64'(obs_log[0].addr), 64'd0);

    // Short low glitch on idle line.
    frames0   = obs_frame;
    busy_seen = 1'b0;
    obs_log.delete();
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk12);
    rx = 1'b1;
    for (int i = 0; i < 6 * CPB; i++) begin
      if (busy) busy_seen = 1'b1;
      @(negedge clk12);
    end
    check_value("glitch_busy",   64'(busy_seen), 64'd0);
    check_value("glitch_frames", 64'(obs_frame - frames0), 64'd0);
    check_value("glitch_words",  64'(obs_log.size()), 64'd0);

    // Framing error aborts the dump.
    frames0 = obs_frame;
    obs_log.delete();
    send_random(5);
    send_byte(8'($urandom), 1'b0, BIT_NS);
    idle_cycles(2 * CPB);
    send_byte(8'hAA, 1'b1, BIT_NS);
    send_byte(8'hBB, 1'b1, BIT_NS);
    send_byte(8'hCC, 1'b1, BIT_NS);
    send_byte(8'hDD, 1'b1, BIT_NS);
    settle();
    check_value("frame_err_pulses", 64'(obs_frame - frames0), 64'd1);
    check_value("frame_words",      64'(obs_log.size()), 64'd2);
    check_value("frame_new_addr",   64'(obs_log[1].addr), 64'd0);
    check_value("frame_new_data",   64'(obs_log[1].data), 64'hDDCCBBAA);

    // Timeout abandons a partial dump.
    timeouts0 = obs_timeout;
    obs_log.delete();
    send_random(6);
    idle_cycles(21 * CPB);
    model_timeout();
    check_value("timeout_pulses", 64'(obs_timeout - timeouts0), 64'd1);
    check_value("timeout_busy",   64'(busy), 64'd0);
    check_value("timeout_words",  64'(obs_log.size()), 64'd1);
    send_random(4);
    settle();
    check_value("timeout_restart_addr", 64'(obs_log[1].addr), 64'd0);

    // Two back-to-back dumps at nominal baud.
    done0 = obs_done;
    obs_log.delete();
    @(negedge clk12);
    send_dump_counting(BIT_NS);
    send_dump_random(BIT_NS);
    settle();
    check_value("b2b_words",      64'(obs_log.size()), 64'd64);
    check_value("b2b_dump_done",  64'(obs_done - done0), 64'd2);
    check_value("b2b_reg1",       64'(obs_log[1].data), 64'h07060504);
    check_value("b2b_reg31",      64'(obs_log[31].data), 64'h7F7E7D7C);
    check_value("b2b_reg31_done", 64'(obs_log[31].done), 64'd1);

    // Two back-to-back dumps with +2% then -2% baud skew.
    done0 = obs_done;
    obs_log.delete();
    @(negedge clk12);
    send_dump_counting(BIT_NS * 1.02);
    send_dump_random(BIT_NS * 0.98);
    settle();
    check_value("skew_words",     64'(obs_log.size()), 64'd64);
    check_value("skew_dump_done", 64'(obs_done - done0), 64'd2);
    check_value("skew_reg31",     64'(obs_log[31].data), 64'h7F7E7D7C);

    check_value("total_frame_err", 64'(obs_frame),   64'(exp_frame));
    check_value("total_timeout",   64'(obs_timeout), 64'(exp_timeout));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
